// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it.
// Pointer arithmetic assumes a power-of-two depth (only 2 is used).
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && rst_n) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Sequential instruction fetch with a small prefetch buffer and redirect support.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into FAULT.
//
// state     | meaning
// ST_IDLE   | after reset, no fetching, buffer drains
// ST_FETCH  | fetching one word per cycle while buffer has room
// ST_HALTED | fetching stopped by halt_i, buffer drains
// ST_FAULT  | misaligned redirect latched, left only by reset
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [ILEN-1:0] imem_data_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            busy_o,
    output logic            misalign_o
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            push, pop, flush, full, empty;
    fetch_entry_t    wentry, head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        flush     = 1'b0;
        if (state != ST_FAULT) begin
            if (redirect_i) begin
                flush = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc_i[1:0] != 2'b00) state_nxt = ST_FAULT;
                else                             pc_nxt    = redirect_pc_i;
`else
                pc_nxt = redirect_pc_i & ~XLEN'(INSTR_BYTES - 1);
`endif
            end else if (state == ST_FETCH && (!full || pop)) begin
                push   = 1'b1;
                pc_nxt = pc + XLEN'(INSTR_BYTES);
            end
            // halt_i has priority over start_i
            if (state_nxt != ST_FAULT) begin
                if (halt_i) begin
                    if (state == ST_FETCH) state_nxt = ST_HALTED;
                end else if (start_i && (state == ST_IDLE || state == ST_HALTED)) begin
                    state_nxt = ST_FETCH;
                end
            end
        end
    end

    assign wentry.pc    = pc;
    assign wentry.instr = imem_data_i;
    assign pop          = !empty && instr_ready_i;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign imem_addr_o   = pc;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign instr_valid_o = !empty;
    assign busy_o        = (state == ST_FETCH);
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_o    = (state == ST_FAULT);
`else
    assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: expected PCs queued as stimulus is driven,
// compared as the DUT delivers instructions. A second instance covers PC wrap.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, redirect, ready;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid, busy, misalign;

    logic        w_start, w_halt, w_ready;
    logic [63:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;
    logic        w_instr_valid, w_busy, w_misalign;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] w_exp_q[$];
    logic [63:0] exp_pc, w_exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    assign imem_data   = imem_word(imem_addr);
    assign w_imem_data = imem_word(w_imem_addr);

    instr_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (ready),
        .busy_o        (busy),
        .misalign_o    (misalign)
    );

    instr_fetch_ctrl #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFF8)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (w_start),
        .halt_i        (w_halt),
        .redirect_i    (1'b0),
        .redirect_pc_i (64'h0),
        .imem_addr_o   (w_imem_addr),
        .imem_data_i   (w_imem_data),
        .instr_o       (w_instr),
        .instr_pc_o    (w_instr_pc),
        .instr_valid_o (w_instr_valid),
        .instr_ready_i (w_ready),
        .busy_o        (w_busy),
        .misalign_o    (w_misalign)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid && ready) begin
            check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check_val("instr_pc", instr_pc, exp_pc);
                check_val("instr", 64'(instr), 64'(imem_word(exp_pc)));
            end
        end
    end

    always @(negedge clk) begin
        if (w_instr_valid && w_ready) begin
            check_val("w_sb_nonempty", 64'(w_exp_q.size() != 0), 64'd1);
            if (w_exp_q.size() != 0) begin
                w_exp_pc = w_exp_q.pop_front();
                check_val("w_instr_pc", w_instr_pc, w_exp_pc);
                check_val("w_instr", 64'(w_instr), 64'(imem_word(w_exp_pc)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; halt = 1'b0; redirect = 1'b0; ready = 1'b0;
        redirect_pc = '0;
        w_start = 1'b0; w_halt = 1'b0; w_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain_and_check(input string tag);
        repeat (4) tick();
        check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        rst_n = 1'b0;
        tick();
        check_val("rst_valid", 64'(instr_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_misalign", 64'(misalign), 64'd0);
        check_val("rst_instr", 64'(instr), 64'd0);
        check_val("rst_instr_pc", instr_pc, 64'd0);
        check_val("rst_imem_addr", imem_addr, 64'd0);
        rst_n = 1'b1;

        // streaming fetch with ready held high
        start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
        tick();
        start = 1'b0;
        check_val("lat_busy", 64'(busy), 64'd1);
        check_val("lat_valid_n1", 64'(instr_valid), 64'd0);
        tick();
        check_val("lat_valid_n2", 64'(instr_valid), 64'd1);
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_val("halt_busy", 64'(busy), 64'd0);
        check_val("halt_addr", imem_addr, 64'd20);
        drain_and_check("stream");

        // back-pressure fills the buffer, then drains in order
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("stall_valid", 64'(instr_valid), 64'd1);
            check_val("stall_pc", instr_pc, 64'd0);
            check_val("stall_instr", 64'(instr), 64'(imem_word(64'd0)));
        end
        check_val("stall_addr", imem_addr, 64'd8);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(4 * i));
        ready = 1'b1;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        drain_and_check("backpressure");

        // redirect while buffer full
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect = 1'b0;
        check_val("redir_valid", 64'(instr_valid), 64'd0);
        check_val("redir_addr", imem_addr, 64'h100);
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h104);
        ready = 1'b1;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        drain_and_check("redirect");

        // halt together with redirect
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
        tick();
        halt = 1'b0; redirect = 1'b0;
        check_val("hr_busy", 64'(busy), 64'd0);
        check_val("hr_valid", 64'(instr_valid), 64'd0);
        check_val("hr_addr", imem_addr, 64'h40);
        exp_q.push_back(64'h40);
        exp_q.push_back(64'h44);
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("hr_restart_valid", 64'(instr_valid), 64'd0);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        drain_and_check("halt_redirect");

        // misaligned redirect
        do_reset();
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
        tick();
        check_val("mis_flag", 64'(misalign), 64'd1);
        check_val("mis_busy", 64'(busy), 64'd0);
        start = 1'b1; redirect_pc = 64'h200;
        repeat (2) tick();
        halt = 1'b1;
        repeat (2) tick();
        start = 1'b0; halt = 1'b0; redirect = 1'b0;
        check_val("mis_sticky", 64'(misalign), 64'd1);
        check_val("mis_valid", 64'(instr_valid), 64'd0);
        check_val("mis_pc_hold", imem_addr, 64'd0);
`else
        tick();
        redirect = 1'b0;
        check_val("mis_flag", 64'(misalign), 64'd0);
        check_val("mis_aligned_addr", imem_addr, 64'h100);
        exp_q.push_back(64'h100);
        halt = 1'b1;
        tick();
        halt = 1'b0;
`endif
        drain_and_check("misalign");
        do_reset();
        check_val("mis_cleared", 64'(misalign), 64'd0);

        // PC wrap on the second instance
        check_val("w_reset_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        w_start = 1'b1; w_ready = 1'b1;
        w_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        w_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        w_exp_q.push_back(64'h0);
        w_exp_q.push_back(64'h4);
        tick();
        w_start = 1'b0;
        repeat (3) tick();
        w_halt = 1'b1;
        tick();
        w_halt = 1'b0;
        repeat (4) tick();
        check_val("w_drained", 64'(w_exp_q.size()), 64'd0);
        check_val("w_halt_addr", w_imem_addr, 64'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning fetch-buffer entries; legal values are 2 only.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port start_i, input, 1, meaning begin or resume fetching.
REQ-006 SHALL have port halt_i, input, 1, meaning stop issuing new fetches.
REQ-007 SHALL have port redirect_i, input, 1, meaning load a new PC (branch/jump).
REQ-008 SHALL have port redirect_pc_i, input, 64, meaning the target byte address.
REQ-009 SHALL have port imem_addr_o, output, 64, meaning the byte address driven to instruction memory (combinational read, data same cycle).
REQ-010 SHALL have port imem_data_i, input, 32, meaning the instruction word returned for imem_addr_o.
REQ-011 SHALL have port instr_o, output, 32, meaning the buffered instruction at the buffer head.
REQ-012 SHALL have port instr_pc_o, output, 64, meaning the PC of instr_o.
REQ-013 SHALL have port instr_valid_o, output, 1, meaning the buffer head is valid.
REQ-014 SHALL have port instr_ready_i, input, 1, meaning the consumer accepts the head this cycle.
REQ-015 SHALL have port busy_o, output, 1, meaning state is FETCH.
REQ-016 SHALL have port misalign_o, output, 1, meaning a misaligned-redirect fault is latched.

Function
REQ-017 SHALL implement states IDLE, FETCH, HALTED and FAULT.
REQ-018 SHALL move IDLE or HALTED to FETCH on start_i, and FETCH to HALTED on halt_i; halt_i wins over a simultaneous start_i.
REQ-019 SHALL drive imem_addr_o = pc in every state.
REQ-020 SHALL, in FETCH with no redirect, push {pc, imem_data_i} and advance pc by 4 when the buffer is not full or a pop occurs in the same cycle.
REQ-021 SHALL treat a pop as instr_valid_o && instr_ready_i; it removes the head in that cycle.
REQ-022 SHALL keep instr_o, instr_pc_o and instr_valid_o stable while instr_valid_o is high and instr_ready_i is low.
REQ-023 SHALL make first-fetch latency two cycles: start_i in cycle N gives FETCH in N+1 and instr_valid_o in N+2.
REQ-024 SHALL, on redirect_i in any state other than FAULT, flush the buffer, load pc <= redirect_pc_i, and perform no push in that cycle; instr_valid_o is 0 in the next cycle.
REQ-025 SHALL change state on a redirect only as required by REQ-018 and REQ-032; halt_i with redirect_i gives HALTED with the new PC.
REQ-026 SHALL continue popping the buffer in HALTED and IDLE; no pushes occur in those states.
REQ-027 SHALL wrap pc from 64'hFFFF_FFFF_FFFF_FFFC to 0 with no flag.
REQ-028 SHALL never push when the buffer is full and no pop occurs, and never pop when it is empty.

Reset
REQ-029 SHALL, with rst_n low at a clock edge, set state = IDLE, pc = RESET_PC, empty the buffer, and set instr_valid_o = 0, busy_o = 0 and misalign_o = 0; instr_o and instr_pc_o read 0.
REQ-030 SHALL, on reset during FETCH, discard buffered entries and suppress that cycle's push.

Configuration
REQ-031 SHALL compile misalignment checking in or out with macro FETCH_MISALIGN_CHECK_EN.
REQ-032 SHALL, when FETCH_MISALIGN_CHECK_EN is defined, on redirect_i with redirect_pc_i[1:0] != 0: enter FAULT, flush the buffer, hold pc, and set misalign_o = 1; FAULT exits only on reset and ignores start_i, halt_i and redirect_i.
REQ-033 SHALL, when FETCH_MISALIGN_CHECK_EN is undefined, load pc <= {redirect_pc_i[63:2], 2'b00}, tie misalign_o to 0, and make FAULT unreachable.

Structure
REQ-034 SHALL place in shared package fetch_pkg: XLEN=64, ILEN=32, INSTR_BYTES=4, the fetch-state enum, and the buffer-entry struct {pc, instr}.
REQ-035 SHALL implement the buffer as sub-module fetch_buf, a 2-entry synchronous FIFO with push, pop, flush, full and empty.

Verification
REQ-036 SHALL cover: reset, then start_i in cycle 1, ready held 1 -> instr_valid_o from cycle 3, instr_pc_o 0,4,8,... one per cycle, instr_o matching memory.
REQ-037 SHALL cover: ready held 0 for 5 cycles in FETCH -> exactly 2 entries buffered, pc stalls at 8, head stays PC 0; ready=1 -> PCs 0,4,8 in order, no gaps or duplicates.
REQ-038 SHALL cover: redirect_i with target 0x100 while 2 entries are buffered -> next cycle instr_valid_o=0; the following delivered PC is 0x100.
REQ-039 SHALL cover: halt_i with redirect_i to 0x40 -> HALTED, buffer empty, imem_addr_o=0x40; start_i -> first PC delivered is 0x40.
REQ-040 SHALL cover: redirect to 0x102 -> with the macro, misalign_o=1, state FAULT, no further valid output until reset; without the macro, next delivered PC is 0x100.
REQ-041 SHALL cover: RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 with ready=1 -> delivered PCs ...FFF8, ...FFFC, 0, 4.
